// File: rtl/mem_write_checker.sv
// Data-memory write-bus checker: ordered table of expected stores,
// ignore address, RUN timeout, sticky status. Optional MWC_FAIL_LOG_EN.
module mem_write_checker #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 1024,
  parameter int IGNORE_ADDR = 96,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int CYC_W = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] data_adr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic              start,
  input  logic              clear,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CYC_W-1:0]  cycle_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL
  } state_t;

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_MISM  = 2'd1;
  localparam logic [1:0] FC_TIME  = 2'd2;
  localparam logic [1:0] FC_EMPTY = 2'd3;

  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [IDX_W:0]    DEPTH_I = (IDX_W + 1)'(DEPTH);
  localparam logic [CYC_W-1:0]  TIME_C  = CYC_W'(TIMEOUT);
  localparam logic [ADDR_W-1:0] IGN_C   = ADDR_W'(IGNORE_ADDR);

  state_t state_q, state_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [1:0]       code_q, code_d;

  logic [ADDR_W-1:0] exp_addr_q [DEPTH];
  logic [DATA_W-1:0] exp_data_q [DEPTH];

  logic              tab_we;
  logic [IDX_W-1:0]  ptr;
  logic [ADDR_W-1:0] exp_a;
  logic [DATA_W-1:0] exp_d;
  logic              addr_hit;
  logic              st_hit;
  logic              st_ign;
  logic              st_bad;
  logic [CNT_W-1:0]  match_inc;
  logic [CYC_W-1:0]  cyc_inc;
  logic [CNT_W-1:0]  count_sel;
  logic              fin;

  // Table is only writable while idle; out-of-range indices are dropped.
  assign tab_we = reset && cfg_we && (state_q == S_IDLE)
               && ({1'b0, cfg_idx} < DEPTH_I);

  // Expected-store table; contents intentionally survive reset and clear.
  always_ff @(posedge clk) begin
    if (tab_we) begin
      exp_addr_q[cfg_idx] <= cfg_addr;
      exp_data_q[cfg_idx] <= cfg_data;
    end
  end

  assign ptr       = match_q[IDX_W-1:0];
  assign exp_a     = exp_addr_q[ptr];
  assign exp_d     = exp_data_q[ptr];
  assign addr_hit  = (data_adr == exp_a);
  assign st_hit    = mem_write && addr_hit && (write_data == exp_d);
  assign st_ign    = mem_write && !addr_hit && (data_adr == IGN_C);
  assign st_bad    = mem_write && !st_hit && !st_ign;
  assign match_inc = match_q + 1'b1;
  assign cyc_inc   = cyc_q + 1'b1;
  assign count_sel = (cfg_count > DEPTH_C) ? DEPTH_C : cfg_count;

  // Next-state and counter updates; store match outranks timeout.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    total_d = total_q;
    cyc_d   = cyc_q;
    code_d  = code_q;
    fin     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          total_d = count_sel;
          match_d = '0;
          cyc_d   = '0;
          code_d  = FC_NONE;
          if (count_sel == '0) begin
            state_d = S_FAIL;
            code_d  = FC_EMPTY;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (clear) begin
          state_d = S_IDLE;
          match_d = '0;
          total_d = '0;
          cyc_d   = '0;
          code_d  = FC_NONE;
        end else begin
          if (st_hit) begin
            match_d = match_inc;
            if (match_inc == total_q) begin
              state_d = S_PASS;
              fin     = 1'b1;
            end
          end else if (st_bad) begin
            state_d = S_FAIL;
            code_d  = FC_MISM;
            fin     = 1'b1;
          end
          if (!fin) begin
            cyc_d = cyc_inc;
            if (cyc_inc == TIME_C) begin
              state_d = S_FAIL;
              code_d  = FC_TIME;
            end
          end
        end
      end
      S_PASS, S_FAIL: begin
        if (clear) begin
          state_d = S_IDLE;
          match_d = '0;
          total_d = '0;
          cyc_d   = '0;
          code_d  = FC_NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      match_q <= '0;
      total_q <= '0;
      cyc_q   <= '0;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      total_q <= total_d;
      cyc_q   <= cyc_d;
      code_q  <= code_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_PASS) || (state_q == S_FAIL);
  assign pass      = (state_q == S_PASS);
  assign fail_code = code_q;
  assign match_cnt = match_q;
  assign cycle_cnt = cyc_q;

`ifdef MWC_FAIL_LOG_EN
  logic [ADDR_W-1:0] fa_q;
  logic [DATA_W-1:0] fd_q;
  logic              cap;

  assign cap = (state_q == S_RUN) && (state_d == S_FAIL)
            && (code_d == FC_MISM);

  // Capture the offending store; zero whenever not sitting in FAIL.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fa_q <= '0;
      fd_q <= '0;
    end else if (cap) begin
      fa_q <= data_adr;
      fd_q <= write_data;
    end else if (state_d != S_FAIL) begin
      fa_q <= '0;
      fd_q <= '0;
    end
  end

  assign fail_addr = fa_q;
  assign fail_data = fd_q;
`else
  assign fail_addr = '0;
  assign fail_data = '0;
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker with a queue-based
// reference model compared every cycle, plus literal pins.
module tb_mem_write_checker;

  localparam int DEP = 4;
  localparam int TO  = 8;
  localparam int IGN = 96;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write;
  logic [31:0] data_adr;
  logic [31:0] write_data;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_addr;
  logic [31:0] cfg_data;
  logic [2:0]  cfg_count;
  logic        start;
  logic        clear;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;
  logic [2:0]  match_cnt;
  logic [3:0]  cycle_cnt;
  logic [31:0] fail_addr;
  logic [31:0] fail_data;

  mem_write_checker #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEP),
    .TIMEOUT(TO), .IGNORE_ADDR(IGN)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_write(mem_write), .data_adr(data_adr),
    .write_data(write_data),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_count(cfg_count), .start(start), .clear(clear),
    .busy(busy), .done(done), .pass(pass),
    .fail_code(fail_code), .match_cnt(match_cnt),
    .cycle_cnt(cycle_cnt), .fail_addr(fail_addr),
    .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a queue of outstanding stores taken at start.
  localparam int MI = 0, MR = 1, MP = 2, MF = 3;
  int          m_st = MI;
  int          m_total = 0;
  int          m_cyc = 0;
  int          m_code = 0;
  logic [31:0] m_fa = '0;
  logic [31:0] m_fd = '0;
  logic [31:0] t_a [DEP];
  logic [31:0] t_d [DEP];
  logic [63:0] pend [$];

  task automatic m_idle();
    m_st = MI; m_total = 0; m_cyc = 0; m_code = 0;
    m_fa = '0; m_fd = '0;
    pend.delete();
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      m_idle();
    end else if (m_st == MI) begin
      if (cfg_we && int'(cfg_idx) < DEP) begin
        t_a[cfg_idx] = cfg_addr;
        t_d[cfg_idx] = cfg_data;
      end
      if (start) begin
        int n;
        n = (int'(cfg_count) > DEP) ? DEP : int'(cfg_count);
        pend.delete();
        for (int i = 0; i < n; i++) pend.push_back({t_a[i], t_d[i]});
        m_total = n; m_cyc = 0; m_code = 0;
        if (n == 0) begin m_st = MF; m_code = 3; end
        else m_st = MR;
      end
    end else if (m_st == MR) begin
      if (clear) m_idle();
      else begin
        bit ended;
        ended = 1'b0;
        if (mem_write && {data_adr, write_data} == pend[0]) begin
          void'(pend.pop_front());
          if (pend.size() == 0) begin m_st = MP; ended = 1'b1; end
        end else if (mem_write && data_adr == IGN
                     && data_adr != pend[0][63:32]) begin
          ended = 1'b0;
        end else if (mem_write) begin
          m_st = MF; m_code = 1; ended = 1'b1;
`ifdef MWC_FAIL_LOG_EN
          m_fa = data_adr; m_fd = write_data;
`endif
        end
        if (!ended) begin
          m_cyc++;
          if (m_cyc == TO) begin m_st = MF; m_code = 2; end
        end
      end
    end else if (clear) begin
      m_idle();
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy", busy, (m_st == MR));
      cmp("done", done, (m_st == MP || m_st == MF));
      cmp("pass", pass, (m_st == MP));
      cmp("fail_code", fail_code, m_code);
      cmp("match_cnt", match_cnt, m_total - pend.size());
      cmp("cycle_cnt", cycle_cnt, m_cyc);
      cmp("fail_addr", fail_addr, m_fa);
      cmp("fail_data", fail_data, m_fd);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load(int idx, int a, int d);
    cfg_we = 1'b1; cfg_idx = 2'(idx);
    cfg_addr = 32'(a); cfg_data = 32'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic go(int n);
    cfg_count = 3'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic store(int a, int d);
    mem_write = 1'b1; data_adr = 32'(a); write_data = 32'(d);
    tick();
    mem_write = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0; mem_write = 1'b0; data_adr = '0; write_data = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
    cfg_count = '0; start = 1'b0; clear = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    cmp("rst_busy", busy, 0);
    cmp("rst_done", done, 0);
    cmp("rst_match", match_cnt, 0);
    reset = 1'b1;

    // single store with an ignored store first
    load(0, 100, 7);
    store(5, 5);
    cmp("idle_store_busy", busy, 0);
    go(1);
    cmp("t1_busy", busy, 1);
    store(96, 55);
    cmp("t1_ign_busy", busy, 1);
    store(100, 7);
    cmp("t1_pass", pass, 1);
    cmp("t1_match", match_cnt, 1);
    cmp("t1_code", fail_code, 0);
    do_clear();
    cmp("t1_clr_done", done, 0);

    // out-of-order store -> mismatch
    load(0, 100, 7);
    load(1, 104, 9);
    go(2);
    store(104, 9);
    cmp("t2_done", done, 1);
    cmp("t2_pass", pass, 0);
    cmp("t2_code", fail_code, 1);
    cmp("t2_match", match_cnt, 0);
`ifdef MWC_FAIL_LOG_EN
    cmp("t2_faddr", fail_addr, 104);
    cmp("t2_fdata", fail_data, 9);
`else
    cmp("t2_faddr", fail_addr, 0);
`endif
    tick();
    cmp("t2_sticky", fail_code, 1);
    do_clear();

    // timeout after exactly TO run cycles
    go(1);
    repeat (TO - 1) tick();
    cmp("t3_busy7", busy, 1);
    cmp("t3_cyc7", cycle_cnt, 7);
    tick();
    cmp("t3_code", fail_code, 2);
    cmp("t3_cyc", cycle_cnt, 8);
    do_clear();

    // final match on the timeout cycle wins
    go(1);
    repeat (TO - 1) tick();
    store(100, 7);
    cmp("t3b_pass", pass, 1);
    cmp("t3b_cyc", cycle_cnt, 7);
    do_clear();

    // empty sequence
    go(0);
    cmp("t4_code", fail_code, 3);
    cmp("t4_done", done, 1);
    do_clear();

    // new table, expected address equal to ignore address
    load(0, 300, 1);
    load(1, 304, 2);
    load(2, 96, 5);
    go(3);
    cmp("t5_match0", match_cnt, 0);
    store(300, 1);
    store(96, 9);
    store(304, 2);
    store(96, 5);
    cmp("t5_pass", pass, 1);
    cmp("t5_match", match_cnt, 3);
    do_clear();

    // ignore address is not tolerated when it is the expected one
    load(0, 96, 5);
    go(1);
    store(96, 6);
    cmp("t5b_code", fail_code, 1);
    do_clear();

    // count clamped to DEPTH
    load(0, 400, 1);
    load(1, 404, 2);
    load(2, 408, 3);
    load(3, 412, 4);
    go(7);
    store(400, 1);
    store(404, 2);
    store(408, 3);
    cmp("clamp_busy", busy, 1);
    store(412, 4);
    cmp("clamp_pass", pass, 1);
    cmp("clamp_match", match_cnt, 4);
    do_clear();

    // clear aborts a run
    load(0, 100, 7);
    go(1);
    store(96, 0);
    do_clear();
    cmp("abort_busy", busy, 0);
    cmp("abort_cyc", cycle_cnt, 0);

    // start and clear together in idle acts as start
    cfg_count = 3'd1; start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    cmp("sc_busy", busy, 1);

    // reset mid-run
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    cmp("mrst_busy", busy, 0);
    cmp("mrst_cyc", cycle_cnt, 0);
    cmp("mrst_done", done, 0);

    // cfg_we during RUN is ignored
    go(1);
    load(0, 200, 1);
    store(100, 7);
    cmp("t6_pass", pass, 1);
    do_clear();
    go(1);
    store(100, 7);
    cmp("t6_keep", pass, 1);
    do_clear();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
